// File: rtl/rc5_round_engine.sv
// ============================================================================
// rc5_round_engine
// ----------------------------------------------------------------------------
// Iterative RC5-32 block-cipher core. One half-round per clock through a
// single shared 32-bit data-dependent left rotator. Subkeys S[0..2R+1] are
// loaded through a write port while the engine is idle; blocks are presented
// with a start/ready handshake and returned with a valid/ready handshake.
//
// Optional feature macro: RC5_DEC_EN
//   defined   -> `mode` selects decrypt; UNWHITEN state, subtractors and
//                rotate-amount negation are built.
//   undefined -> encrypt-only; `mode` is ignored.
//
// Parameters
//   ROUNDS      number of RC5 rounds R (1..15, so 2R+2 <= 32 subkeys)
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   sk_we       subkey write strobe (honoured only while ready = 1)
//   sk_addr     subkey index (writes with index >= 2R+2 are dropped)
//   sk_din      subkey value
//   start       request to process din (accepted while ready = 1)
//   mode        0 = encrypt, 1 = decrypt (decrypt only with RC5_DEC_EN)
//   din         input block, A = din[31:0], B = din[63:32]
//   ready       engine idle, start will be accepted
//   dout        result block {B, A}
//   dout_valid  dout holds a finished block
//   dout_ready  consumer accepts dout
// ============================================================================

// ----------------------------------------------------------------------------
// 32-bit left rotator, 5-bit amount. The upper half of {x,x} << r is
// exactly ROL(x, r), including r = 0.
// ----------------------------------------------------------------------------
module rc5_rol32 (
    input  logic [31:0] i_x,
    input  logic [4:0]  i_amt,
    output logic [31:0] o_y
);
    logic [63:0] w_dbl;

    assign w_dbl = {i_x, i_x} << i_amt;
    assign o_y   = w_dbl[63:32];
endmodule

module rc5_round_engine #(
    parameter int ROUNDS = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sk_we,
    input  logic [4:0]  sk_addr,
    input  logic [31:0] sk_din,
    input  logic        start,
    input  logic        mode,
    input  logic [63:0] din,
    output logic        ready,
    output logic [63:0] dout,
    output logic        dout_valid,
    input  logic        dout_ready
);
    localparam int         NSK    = 2 * ROUNDS + 2;
    localparam logic [5:0] NSK6   = 6'(NSK);
    localparam logic [4:0] H_LAST = 5'(2 * ROUNDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WHITEN,
        S_ROUND,
`ifdef RC5_DEC_EN
        S_UNWHITEN,
`endif
        S_DONE
    } state_t;

    state_t      r_state;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [4:0]  r_h;
    logic [31:0] r_sk [NSK];
    logic        r_ready;
    logic [63:0] r_dout;
    logic        r_dout_valid;

    logic        w_dec;
    logic        w_tgt_a;
    logic [31:0] w_t;
    logic [31:0] w_o;
    logic [4:0]  w_sk_idx;
    logic [31:0] w_sk;
    logic [31:0] w_rot_in;
    logic [4:0]  w_rot_amt;
    logic [31:0] w_rot_out;
    logic [31:0] w_new;

`ifdef RC5_DEC_EN
    logic        r_dec;
    assign w_dec = r_dec;
`else
    logic        w_unused_mode;
    assign w_dec         = 1'b0;
    assign w_unused_mode = mode;
`endif

    // Each half-round updates exactly one word. Encrypt alternates A,B
    // starting with A; decrypt alternates B,A starting with B. Either way
    // the updated word is A when h[0] equals the direction bit.
    assign w_tgt_a = ~(r_h[0] ^ w_dec);
    assign w_t     = w_tgt_a ? r_a : r_b;
    assign w_o     = w_tgt_a ? r_b : r_a;

    // Both half-rounds of round i use consecutive subkeys, so the subkey
    // index walks linearly with h: h+2 upward for encrypt, 2R+1-h downward
    // for decrypt.
`ifdef RC5_DEC_EN
    assign w_sk_idx  = w_dec ? (5'(NSK - 1) - r_h) : (r_h + 5'd2);
`else
    assign w_sk_idx  = r_h + 5'd2;
`endif
    assign w_sk = r_sk[w_sk_idx];

`ifdef RC5_DEC_EN
    // ROR by r is ROL by (32-r) mod 32; 5-bit negation wraps 0 to 0.
    assign w_rot_in  = w_dec ? (w_t - w_sk) : (w_t ^ w_o);
    assign w_rot_amt = w_dec ? (5'd0 - w_o[4:0]) : w_o[4:0];
    assign w_new     = w_dec ? (w_rot_out ^ w_o) : (w_rot_out + w_sk);
`else
    assign w_rot_in  = w_t ^ w_o;
    assign w_rot_amt = w_o[4:0];
    assign w_new     = w_rot_out + w_sk;
`endif

    rc5_rol32 u_rol (
        .i_x   (w_rot_in),
        .i_amt (w_rot_amt),
        .o_y   (w_rot_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_a          <= '0;
            r_b          <= '0;
            r_h          <= '0;
            r_ready      <= 1'b1;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
`ifdef RC5_DEC_EN
            r_dec        <= 1'b0;
`endif
            for (int k = 0; k < NSK; k++) begin
                r_sk[k] <= '0;
            end
        end else begin
            // Subkey file only accepts writes while idle so a running block
            // always sees a consistent schedule.
            if (sk_we && r_ready && ({1'b0, sk_addr} < NSK6)) begin
                r_sk[sk_addr] <= sk_din;
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= din[31:0];
                        r_b     <= din[63:32];
                        r_h     <= '0;
                        r_ready <= 1'b0;
`ifdef RC5_DEC_EN
                        r_dec   <= mode;
                        r_state <= mode ? S_ROUND : S_WHITEN;
`else
                        r_state <= S_WHITEN;
`endif
                    end
                end

                S_WHITEN: begin
                    r_a     <= r_a + r_sk[0];
                    r_b     <= r_b + r_sk[1];
                    r_state <= S_ROUND;
                end

                S_ROUND: begin
                    if (w_tgt_a) begin
                        r_a <= w_new;
                    end else begin
                        r_b <= w_new;
                    end
                    r_h <= r_h + 5'd1;
                    if (r_h == H_LAST) begin
`ifdef RC5_DEC_EN
                        r_state <= w_dec ? S_UNWHITEN : S_DONE;
`else
                        r_state <= S_DONE;
`endif
                    end
                end

`ifdef RC5_DEC_EN
                S_UNWHITEN: begin
                    r_a     <= r_a - r_sk[0];
                    r_b     <= r_b - r_sk[1];
                    r_state <= S_DONE;
                end
`endif

                S_DONE: begin
                    // First DONE cycle publishes the result; afterwards it is
                    // held until the consumer takes it.
                    if (!r_dout_valid) begin
                        r_dout       <= {r_b, r_a};
                        r_dout_valid <= 1'b1;
                    end else if (dout_ready) begin
                        r_dout_valid <= 1'b0;
                        r_ready      <= 1'b1;
                        r_state      <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign ready      = r_ready;
    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
endmodule
